sprite_layer_engine: RTL and testbench
======================================

// Module: sprite_layer_engine
// PURPOSE
//  Parametrised N-channel sprite compositor on the VGA pixel path. Per channel: screen position, 8-way orientation, integer scale.
//  Emits ROM addresses to external synchronous sprite ROMs, does transparency keying and fixed-priority compositing over a background.
//  Palette lookup follows. Sits between the VGA controller (DrawX/DrawY/blank) and the DAC. Positions are frame-coherent.
// PARAMETERS
//  N_CH        4    number of sprite channels; channel 0 has highest priority
//  SPR_W       14   sprite width in texels
//  SPR_H       14   sprite height in texels
//  IDX_W       2    palette index width; index 0 is transparent
//  ANIM_FRAMES 2    frames per ROM (only with SPRITE_ANIM_EN)
//  ANIM_DIV    8    video frames per animation step (only with SPRITE_ANIM_EN)
//  ADDR_W      $clog2(SPR_W*SPR_H*ANIM_FRAMES) ROM address width (derived localparam)
// PORTS
//  vga_clk     in   1             pixel clock; all logic on posedge
//  reset_n     in   1             asynchronous, active-low reset
//  DrawX       in   10            current pixel column
//  DrawY       in   10            current pixel row
//  blank       in   1             1 = active video (0 forces black output)
//  frame_start in   1             one-cycle pulse from the VGA controller at start of vertical blank
//  ch_en       in   N_CH          per-channel enable (sampled at frame_start)
//  ch_x, ch_y  in   N_CH x 10     sprite top-left position (sampled at frame_start)
//  ch_orient   in   N_CH x 3      {transpose, flip_y, flip_x} (sampled at frame_start)
//  ch_scale    in   N_CH x 2      log2 scale factor, 0..3 = 1x..8x (sampled at frame_start)
//  rom_addr    out  N_CH x ADDR_W address to channel ROM; data returns 1 cycle later on rom_q
//  rom_q       in   N_CH x IDX_W  ROM palette index
//  bg_rgb      in   12            background colour {r,g,b}, aligned with DrawX (block delays it)
//  red/green/blue out 4 each      composited pixel
//  hit_ch      out  $clog2(N_CH)+1 winning channel; all-ones = background
// BEHAVIOUR
//  Reset: shadow regs, pipeline valids, rom_addr, RGB and anim counters -> 0; hit_ch -> all-ones. No transaction survives reset.
//  Shadow: on frame_start, all ch_* inputs are copied to shadow regs at once. Rendering uses only the shadows, so there is no mid-frame tearing.
//  Pipeline: S0 = hit test and address, registered into rom_addr. S1 = ROM read; hit, delayed bg and blank ride alongside.
//   S2 = key, priority, palette, register to red/green/blue. Output for pixel (DrawX,DrawY) appears exactly 2 cycles later.
//  Hit test: dx = {1'b0,DrawX} - {1'b0,sx}, 11-bit signed; dy likewise. Hit iff ch_en, dx>=0, dy>=0, (dx>>scale)<SPR_W and (dy>>scale)<SPR_H.
//   Screen edges clip naturally. Positions do not wrap.
//  Texel: u=dx>>scale, v=dy>>scale. flip_x: u=SPR_W-1-u. flip_y: v=SPR_H-1-v. transpose: swap u and v, legal only when SPR_W==SPR_H.
//   Otherwise transpose is ignored (elaboration assertion warns).
//   Order of operations: transpose first, then flips.
//  Address: rom_addr = frame*SPR_W*SPR_H + v*SPR_W + u. On a miss, rom_addr holds 0 and the stage-1 hit bit is 0.
//  Composite: lowest-index channel with hit && rom_q!=0 wins and drives its palette colour; hit_ch = that index.
//   No winner: bg_rgb passes through and hit_ch is all-ones. blank==0 in S2: RGB = 0, hit_ch all-ones.
//  frame_start coincident with an active pixel: shadows update that edge. Pixels already in S1/S2 keep their captured values.
// CONFIGURATION
//  SPRITE_ANIM_EN defined: a divider counts frame_start pulses. Every ANIM_DIV pulses, frame increments modulo ANIM_FRAMES (ANIM_FRAMES-1 -> 0).
//   All channels share frame. frame changes only at frame_start.
//  SPRITE_ANIM_EN undefined: frame is constant 0, no counters, ANIM_* ignored, ADDR_W = $clog2(SPR_W*SPR_H).
// STRUCTURE
//  sprite_pkg: orient_t struct {transpose, flip_y, flip_x}, NO_HIT constant, TRANSPARENT_IDX = 0.
//   Also function palette_rgb(idx) -> 12-bit colour.
//  Sub-module sprite_channel_xform: one per channel via generate. Takes DrawX/DrawY, shadow position, orient, scale and frame.
//   Produces hit and address, combinational. The top holds shadows, counters, pipeline and priority mux.
// TESTING
//  1. Reset mid-frame: assert reset_n=0 while sprite visible. Same cycle RGB=0, hit_ch=all-ones. After release, output black/bg until next frame_start.
//  2. ch0 at (100,50), scale 0, orient 0. Pixel (100,50) gives rom_addr=0; (113,63) gives 195; (114,50) is a miss.
//   RGB appears exactly 2 cycles after the matching DrawX.
//  3. Orient 3'b011 at (0,0): pixel (0,0) gives addr 195. Orient 3'b100: pixel (1,0) gives addr 14.
//   Scale 2 at (0,0): pixels (0..3,0) all give addr 0; pixel (55,0) hits, pixel (56,0) misses.
//  4. ch0 and ch1 overlap at the same pixel. ch0 rom_q=0 -> ch1 colour, hit_ch=1. ch0 rom_q=2 -> ch0 colour, hit_ch=0.
//   Both rom_q=0 -> bg_rgb passes through.
//  5. Change ch_x mid-frame without frame_start: no effect. Pulse frame_start during an active pixel: the next pixel uses the new x.
//  6. With SPRITE_ANIM_EN, ANIM_DIV=2, ANIM_FRAMES=2: frame goes 0,0,1,1,0 across frame_start pulses. Pixel (x0,y0) addr alternates 0 and 196.

Source files
------------

// File: rtl/sprite_layer_engine_pkg.sv
// rtl/sprite_layer_engine_pkg.sv - shared types, constants and palette for the sprite layer engine
package sprite_pkg;

    typedef struct packed {
        logic transpose;
        logic flip_y;
        logic flip_x;
    } orient_t;

    // Truncated to the hit_ch width at the point of use, so it is all-ones for any N_CH.
    localparam logic [7:0] NO_HIT          = 8'hFF;
    localparam int         TRANSPARENT_IDX = 0;

    function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
        logic [11:0] rgb;
        case (idx)
            4'd0:    rgb = 12'h000;
            4'd1:    rgb = 12'hF00;
            4'd2:    rgb = 12'h0F0;
            4'd3:    rgb = 12'h00F;
            default: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/sprite_layer_engine_if.sv
// rtl/sprite_layer_engine_if.sv - per-channel sprite ROM address/data bus
interface sprite_rom_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 2
);
    logic [N_CH-1:0][ADDR_W-1:0] rom_addr;
    logic [N_CH-1:0][IDX_W-1:0]  rom_q;

    modport master (output rom_addr, input rom_q);
    modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/sprite_channel_xform.sv
// rtl/sprite_channel_xform.sv - per-channel hit test and texel address (combinational)
module sprite_channel_xform
    import sprite_pkg::*;
#(
    parameter int SPR_W   = 14,
    parameter int SPR_H   = 14,
    parameter int ADDR_W  = 8,
    parameter int FRAME_W = 1
) (
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic [9:0]         sx,
    input  logic [9:0]         sy,
    input  logic               en,
    input  orient_t            orient,
    input  logic [1:0]         scale,
    input  logic [FRAME_W-1:0] frame,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);
    localparam bit         SQUARE = (SPR_W == SPR_H);
    localparam logic [9:0] W_M1   = 10'(SPR_W - 1);
    localparam logic [9:0] H_M1   = 10'(SPR_H - 1);

    if (!SQUARE) begin : g_nonsquare
        $warning("sprite_channel_xform: transpose ignored for non-square sprites");
    end

    logic [10:0] dx, dy;
    logic [9:0]  u_s, v_s, u_t, v_t, u_f, v_f;
    logic [31:0] lin;

    always_comb begin
        dx  = {1'b0, draw_x} - {1'b0, sx};
        dy  = {1'b0, draw_y} - {1'b0, sy};
        u_s = dx[9:0] >> scale;
        v_s = dy[9:0] >> scale;
        hit = en && !dx[10] && !dy[10] && (u_s <= W_M1) && (v_s <= H_M1);
        // Transpose happens before the flips, so flip_x always mirrors the stored column.
        u_t = (SQUARE && orient.transpose) ? v_s : u_s;
        v_t = (SQUARE && orient.transpose) ? u_s : v_s;
        u_f = orient.flip_x ? (W_M1 - u_t) : u_t;
        v_f = orient.flip_y ? (H_M1 - v_t) : v_t;
        lin = 32'(frame) * 32'(SPR_W * SPR_H) + 32'(v_f) * 32'(SPR_W) + 32'(u_f);
        addr = hit ? ADDR_W'(lin) : '0;
    end

endmodule

// File: rtl/sprite_layer_engine.sv
// rtl/sprite_layer_engine.sv - N-channel sprite compositor; SPRITE_ANIM_EN enables shared frame animation
module sprite_layer_engine
    import sprite_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SPR_W       = 14,
    parameter int SPR_H       = 14,
    parameter int IDX_W       = 2,
    parameter int ANIM_FRAMES = 2,
    parameter int ANIM_DIV    = 8,
    localparam int HW         = $clog2(N_CH) + 1
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic                  blank,
    input  logic                  frame_start,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0][9:0]  ch_x,
    input  logic [N_CH-1:0][9:0]  ch_y,
    input  orient_t [N_CH-1:0]    ch_orient,
    input  logic [N_CH-1:0][1:0]  ch_scale,
    sprite_rom_if.master          rom,
    input  logic [11:0]           bg_rgb,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic [HW-1:0]         hit_ch
);
    localparam logic [HW-1:0] NO_HIT_W = HW'(NO_HIT);

    if (ANIM_FRAMES < 1 || ANIM_DIV < 1) begin : g_bad_anim
        $error("sprite_layer_engine: ANIM_FRAMES and ANIM_DIV must be >= 1");
    end

`ifdef SPRITE_ANIM_EN
    localparam int ADDR_W  = $clog2(SPR_W * SPR_H * ANIM_FRAMES);
    localparam int FRAME_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        div_d   = div_q;
        frame_d = frame_q;
        if (frame_start) begin
            if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_d   = '0;
                frame_d = (frame_q == FRAME_W'(ANIM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            frame_q <= '0;
        end else begin
            div_q   <= div_d;
            frame_q <= frame_d;
        end
    end
`else
    localparam int ADDR_W  = $clog2(SPR_W * SPR_H);
    localparam int FRAME_W = 1;

    logic [FRAME_W-1:0] frame_q;
    assign frame_q = '0;
`endif

    // Shadow copies: rendering never sees ch_* directly, so a frame is never torn.
    logic [N_CH-1:0]      en_q;
    logic [N_CH-1:0][9:0] x_q, y_q;
    orient_t [N_CH-1:0]   orient_q;
    logic [N_CH-1:0][1:0] scale_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            orient_q <= '0;
            scale_q  <= '0;
        end else if (frame_start) begin
            en_q     <= ch_en;
            x_q      <= ch_x;
            y_q      <= ch_y;
            orient_q <= ch_orient;
            scale_q  <= ch_scale;
        end
    end

    logic [N_CH-1:0]             hit_d;
    logic [N_CH-1:0][ADDR_W-1:0] addr_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sprite_channel_xform #(
            .SPR_W   (SPR_W),
            .SPR_H   (SPR_H),
            .ADDR_W  (ADDR_W),
            .FRAME_W (FRAME_W)
        ) u_xform (
            .draw_x (DrawX),
            .draw_y (DrawY),
            .sx     (x_q[i]),
            .sy     (y_q[i]),
            .en     (en_q[i]),
            .orient (orient_q[i]),
            .scale  (scale_q[i]),
            .frame  (frame_q),
            .hit    (hit_d[i]),
            .addr   (addr_d[i])
        );
    end

    logic [N_CH-1:0] hit1_q, hit2_q;
    logic [11:0]     bg1_q, bg2_q, rgb_q, rgb_d;
    logic            blank1_q, blank2_q;
    logic [HW-1:0]   hit_ch_q, hit_ch_d;

    // Channels scanned high to low so the lowest opaque index overwrites last and wins.
    always_comb begin
        rgb_d    = bg2_q;
        hit_ch_d = NO_HIT_W;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hit2_q[i] && rom.rom_q[i] != IDX_W'(TRANSPARENT_IDX)) begin
                rgb_d    = palette_rgb(4'(rom.rom_q[i]));
                hit_ch_d = HW'(i);
            end
        end
        if (!blank2_q) begin
            rgb_d    = '0;
            hit_ch_d = NO_HIT_W;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom.rom_addr <= '0;
            hit1_q       <= '0;
            bg1_q        <= '0;
            blank1_q     <= 1'b0;
            hit2_q       <= '0;
            bg2_q        <= '0;
            blank2_q     <= 1'b0;
            rgb_q        <= '0;
            hit_ch_q     <= NO_HIT_W;
        end else begin
            rom.rom_addr <= addr_d;
            hit1_q       <= hit_d;
            bg1_q        <= bg_rgb;
            blank1_q     <= blank;
            hit2_q       <= hit1_q;
            bg2_q        <= bg1_q;
            blank2_q     <= blank1_q;
            rgb_q        <= rgb_d;
            hit_ch_q     <= hit_ch_d;
        end
    end

    assign red    = rgb_q[11:8];
    assign green  = rgb_q[7:4];
    assign blue   = rgb_q[3:0];
    assign hit_ch = hit_ch_q;

endmodule

// File: tb/tb_sprite_layer_engine.sv
// tb/tb_sprite_layer_engine.sv - directed table-driven bench for sprite_layer_engine
module tb_sprite_layer_engine;
    import sprite_pkg::*;

    localparam int N_CH  = 4;
    localparam int SPR_W = 14;
    localparam int SPR_H = 14;
    localparam int IDX_W = 2;
`ifdef SPRITE_ANIM_EN
    localparam int ANIM_FRAMES = 2;
    localparam int ANIM_DIV    = 2;
    localparam int ADDR_W      = $clog2(SPR_W * SPR_H * ANIM_FRAMES);
`else
    localparam int ANIM_FRAMES = 2;
    localparam int ANIM_DIV    = 8;
    localparam int ADDR_W      = $clog2(SPR_W * SPR_H);
`endif
    localparam int HW = $clog2(N_CH) + 1;
    localparam int BG = 'h5A5;
    localparam int NH = (1 << HW) - 1;

    logic                 vga_clk;
    logic                 reset_n;
    logic [9:0]           DrawX, DrawY;
    logic                 blank, frame_start;
    logic [N_CH-1:0]      ch_en;
    logic [N_CH-1:0][9:0] ch_x, ch_y;
    logic [N_CH-1:0][2:0] ch_orient;
    logic [N_CH-1:0][1:0] ch_scale;
    logic [11:0]          bg_rgb;
    logic [3:0]           red, green, blue;
    logic [HW-1:0]        hit_ch;
    logic [11:0]          rgb;
    logic [IDX_W-1:0]     rom_val [N_CH];

    int total = 0;
    int bad   = 0;

    sprite_rom_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) rom ();

    sprite_layer_engine #(
        .N_CH(N_CH), .SPR_W(SPR_W), .SPR_H(SPR_H), .IDX_W(IDX_W),
        .ANIM_FRAMES(ANIM_FRAMES), .ANIM_DIV(ANIM_DIV)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .ch_en(ch_en), .ch_x(ch_x),
        .ch_y(ch_y), .ch_orient(ch_orient), .ch_scale(ch_scale), .rom(rom),
        .bg_rgb(bg_rgb), .red(red), .green(green), .blue(blue), .hit_ch(hit_ch)
    );

    assign rgb = {red, green, blue};

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM: one cycle from address to data, content chosen per channel.
    always @(posedge vga_clk)
        for (int i = 0; i < N_CH; i++) rom.rom_q[i] <= rom_val[i];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int en, sx, sy, o, sc, px, py, hit, addr;
    } vec_t;

    vec_t vecs [15];

    task automatic step;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input int bl);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = 1'(bl);
    endtask

    task automatic load(input int ch, input int en, input int sx, input int sy, input int o, input int sc);
        ch_en[ch]     = 1'(en);
        ch_x[ch]      = 10'(sx);
        ch_y[ch]      = 10'(sy);
        ch_orient[ch] = 3'(o);
        ch_scale[ch]  = 2'(sc);
    endtask

    task automatic pulse;
        frame_start = 1'b1;
        blank       = 1'b0;
        step();
        frame_start = 1'b0;
    endtask

    // Presents one active pixel, then returns with its output registered (two edges later).
    task automatic shoot(input int x, input int y, input int bl);
        pix(x, y, bl);
        step();
        pix(0, 0, 0);
        step();
        step();
    endtask

    initial begin
        //          en  sx   sy  o  sc   px    py  hit addr
        vecs[0]  = '{1, 100, 50, 0, 0, 100,   50, 1,   0};
        vecs[1]  = '{1, 100, 50, 0, 0, 113,   63, 1, 195};
        vecs[2]  = '{1, 100, 50, 0, 0, 114,   50, 0,   0};
        vecs[3]  = '{1, 100, 50, 0, 0,  99,   50, 0,   0};
        vecs[4]  = '{1,   0,  0, 3, 0,   0,    0, 1, 195};
        vecs[5]  = '{1,   0,  0, 4, 0,   1,    0, 1,  14};
        vecs[6]  = '{1,   0,  0, 0, 2,   3,    0, 1,   0};
        vecs[7]  = '{1,   0,  0, 0, 2,  55,    0, 1,  13};
        vecs[8]  = '{1,   0,  0, 0, 2,  56,    0, 0,   0};
        vecs[9]  = '{1,   0,  0, 5, 0,   2,    5, 1,  36};
        vecs[10] = '{1,  10, 20, 1, 1,  15,   27, 1,  53};
        vecs[11] = '{0, 100, 50, 0, 0, 100,   50, 0,   0};
        vecs[12] = '{1, 900,  0, 0, 3, 1011,   0, 1,  13};
        vecs[13] = '{1, 900,  0, 0, 3, 1023,   0, 0,   0};
        vecs[14] = '{1,   0,  0, 2, 0,   3,    4, 1, 129};

        reset_n     = 1'b0;
        frame_start = 1'b0;
        bg_rgb      = 12'(BG);
        ch_en       = '0;
        ch_x        = '0;
        ch_y        = '0;
        ch_orient   = '0;
        ch_scale    = '0;
        pix(0, 0, 0);
        for (int i = 0; i < N_CH; i++) rom_val[i] = '0;
        rom_val[0] = 2'd1;
        step();
        step();
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_hit_ch", int'(hit_ch), NH);
        chk("reset_rom_addr", int'(rom.rom_addr[0]), 0);
        reset_n = 1'b1;
        step();

        for (int k = 0; k < 15; k++) begin
            ch_en = '0;
            load(0, vecs[k].en, vecs[k].sx, vecs[k].sy, vecs[k].o, vecs[k].sc);
            pulse();
            pix(vecs[k].px, vecs[k].py, 1);
            step();
            chk($sformatf("vec%0d_addr", k), int'(rom.rom_addr[0]), vecs[k].addr);
            pix(0, 0, 0);
            step();
            step();
            chk($sformatf("vec%0d_hit_ch", k), int'(hit_ch), vecs[k].hit != 0 ? 0 : NH);
            chk($sformatf("vec%0d_rgb", k), int'(rgb), vecs[k].hit != 0 ? 'hF00 : BG);
        end

        // Latency: output is idle one edge early and follows the pixel exactly two edges later.
        ch_en = '0;
        load(0, 1, 100, 50, 0, 0);
        pulse();
        pix(100, 50, 1);
        step();
        pix(0, 0, 1);
        step();
        chk("lat_early_hit_ch", int'(hit_ch), NH);
        chk("lat_early_rgb", int'(rgb), 0);
        step();
        chk("lat_hit_ch", int'(hit_ch), 0);
        chk("lat_rgb", int'(rgb), 'hF00);
        step();
        chk("lat_next_rgb", int'(rgb), BG);

        // Priority between two overlapping channels.
        load(1, 1, 100, 50, 0, 0);
        pulse();
        rom_val[0] = 2'd0; rom_val[1] = 2'd3;
        shoot(100, 50, 1);
        chk("prio_ch1_hit_ch", int'(hit_ch), 1);
        chk("prio_ch1_rgb", int'(rgb), 'h00F);
        rom_val[0] = 2'd2;
        shoot(100, 50, 1);
        chk("prio_ch0_hit_ch", int'(hit_ch), 0);
        chk("prio_ch0_rgb", int'(rgb), 'h0F0);
        rom_val[0] = 2'd0; rom_val[1] = 2'd0;
        shoot(100, 50, 1);
        chk("prio_bg_hit_ch", int'(hit_ch), NH);
        chk("prio_bg_rgb", int'(rgb), BG);
        rom_val[0] = 2'd2;
        shoot(100, 50, 0);
        chk("blank_hit_ch", int'(hit_ch), NH);
        chk("blank_rgb", int'(rgb), 0);

        // Shadowing: ch_x changes only take effect at frame_start.
        ch_en = '0;
        rom_val[0] = 2'd1; rom_val[1] = 2'd0;
        load(0, 1, 100, 50, 0, 0);
        pulse();
        ch_x[0] = 10'd200;
        shoot(100, 50, 1);
        chk("shadow_hold_hit_ch", int'(hit_ch), 0);
        frame_start = 1'b1;
        pix(100, 50, 1);
        step();
        frame_start = 1'b0;
        pix(200, 50, 1);
        step();
        pix(100, 50, 1);
        step();
        chk("fs_same_edge_old_x", int'(hit_ch), 0);
        pix(0, 0, 0);
        step();
        chk("fs_next_new_x", int'(hit_ch), 0);
        step();
        chk("fs_old_x_gone", int'(hit_ch), NH);
        chk("fs_old_x_gone_rgb", int'(rgb), BG);

        // Reset while the sprite is on screen.
        load(0, 1, 100, 50, 0, 0);
        pulse();
        pix(100, 50, 1);
        step();
        step();
        step();
        chk("pre_reset_hit_ch", int'(hit_ch), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_rgb", int'(rgb), 0);
        chk("mid_reset_hit_ch", int'(hit_ch), NH);
        chk("mid_reset_rom_addr", int'(rom.rom_addr[0]), 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        chk("post_reset_hit_ch", int'(hit_ch), NH);
        chk("post_reset_rgb", int'(rgb), BG);
        pulse();
        pix(100, 50, 1);
        step();
        step();
        step();
        chk("post_reset_fs_hit_ch", int'(hit_ch), 0);

`ifdef SPRITE_ANIM_EN
        begin
            int exp_addr [4];
            exp_addr = '{0, 196, 196, 0};
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            load(0, 1, 100, 50, 0, 0);
            for (int j = 0; j < 4; j++) begin
                pulse();
                pix(100, 50, 1);
                step();
                chk($sformatf("anim%0d_addr", j), int'(rom.rom_addr[0]), exp_addr[j]);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
